// File: rtl/udp_rx_unpack.sv
// udp_rx_unpack: GMII receive-side Ethernet/IPv4/UDP parser.
// Filters on local MAC (or broadcast), local IPv4 address and local UDP port,
// then packs the UDP payload into 64-bit words (first byte in [63:56]).
//
// Ports:
//   clk             GMII receive clock, rising edge
//   reset           asynchronous active-high reset
//   e_rxdv, e_rxd   GMII receive valid / byte
//   fifo_full       RX FIFO almost-full
//   wr_en, dout     FIFO write strobe and packed payload word
//   rx_total_length IP total length of last accepted frame
//   rx_data_length  UDP length of last accepted frame
//   data_receive    one-cycle pulse, good frame complete
//   rx_overflow     one-cycle pulse, word dropped on fifo_full
//   rx_state        current FSM state, debug
//
// state    | meaning
// IDLE     | waiting for first preamble byte
// PREAMBLE | counting 0x55 bytes, waiting for SFD 0xD5
// MAC_HDR  | 14-byte Ethernet header, dest MAC and EtherType check
// IP_HDR   | 20-byte IPv4 header, version/IHL, protocol, dest IP check
// UDP_HDR  | 8-byte UDP header, dest port check, length capture
// DATA     | packing payload bytes into 64-bit words
// WAIT_END | payload done, waiting for rxdv to fall
// DROP     | frame rejected, waiting for rxdv to fall
module udp_rx_unpack #(
  parameter logic [47:0] LOCAL_MAC  = 48'h000A_3501_FEC0,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0002,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_rxdv,
  input  logic [7:0]  e_rxd,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [63:0] dout,
  output logic [15:0] rx_total_length,
  output logic [15:0] rx_data_length,
  output logic        data_receive,
  output logic        rx_overflow,
  output logic [3:0]  rx_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PREAMBLE = 4'd1,
    S_MAC_HDR  = 4'd2,
    S_IP_HDR   = 4'd3,
    S_UDP_HDR  = 4'd4,
    S_DATA     = 4'd5,
    S_WAIT_END = 4'd6,
    S_DROP     = 4'd7
  } state_t;

  state_t      state;
  logic [2:0]  pre_cnt;
  logic [4:0]  byte_cnt;
  logic        mac_loc_ok;
  logic        mac_bc_ok;
  logic [15:0] total_len_sh;
  logic [15:0] udp_len_sh;
  logic [15:0] data_left;
  logic [63:0] pack;
  logic [2:0]  lane;
  logic        ovf_err;

  logic [7:0]  mac_byte;
  logic [7:0]  ip_byte;
  logic        mac_loc_hit;
  logic        mac_bc_hit;
  logic [63:0] next_pack;

  assign rx_state = state;

  always_comb begin
    mac_byte = LOCAL_MAC[7:0];
    case (byte_cnt[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      default: mac_byte = LOCAL_MAC[7:0];
    endcase
    ip_byte = LOCAL_IP[7:0];
    case (byte_cnt[1:0])
      2'd0:    ip_byte = LOCAL_IP[31:24];
      2'd1:    ip_byte = LOCAL_IP[23:16];
      2'd2:    ip_byte = LOCAL_IP[15:8];
      default: ip_byte = LOCAL_IP[7:0];
    endcase
    // Unicast and broadcast matches are tracked separately so a mix of the
    // two (e.g. FF followed by local bytes) is rejected.
    mac_loc_hit = (e_rxd == mac_byte) && ((byte_cnt == 5'd0) || mac_loc_ok);
    mac_bc_hit  = (e_rxd == 8'hFF) && ((byte_cnt == 5'd0) || mac_bc_ok);
    // Lane 0 lands in [63:56]; ~lane equals 7-lane for a 3-bit index.
    next_pack   = pack | ({56'd0, e_rxd} << {~lane, 3'b000});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      pre_cnt         <= 3'd0;
      byte_cnt        <= 5'd0;
      mac_loc_ok      <= 1'b0;
      mac_bc_ok       <= 1'b0;
      total_len_sh    <= 16'd0;
      udp_len_sh      <= 16'd0;
      data_left       <= 16'd0;
      pack            <= 64'd0;
      lane            <= 3'd0;
      ovf_err         <= 1'b0;
      wr_en           <= 1'b0;
      dout            <= 64'd0;
      rx_total_length <= 16'd0;
      rx_data_length  <= 16'd0;
      data_receive    <= 1'b0;
      rx_overflow     <= 1'b0;
    end else begin
      wr_en        <= 1'b0;
      data_receive <= 1'b0;
      rx_overflow  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (e_rxdv && (e_rxd == 8'h55)) begin
            state   <= S_PREAMBLE;
            pre_cnt <= 3'd1;
          end
        end
        S_PREAMBLE: begin
          if (!e_rxdv) begin
            state <= S_IDLE;
          end else if (e_rxd == 8'h55) begin
            if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
          end else if ((e_rxd == 8'hD5) && (pre_cnt >= 3'd6)) begin
            state    <= S_MAC_HDR;
            byte_cnt <= 5'd0;
            ovf_err  <= 1'b0;
          end else begin
            state <= S_DROP;
          end
        end
        S_MAC_HDR: begin
          if (!e_rxdv) begin
            state <= S_IDLE;
          end else begin
            byte_cnt <= byte_cnt + 5'd1;
            if (byte_cnt < 5'd6) begin
              mac_loc_ok <= mac_loc_hit;
              mac_bc_ok  <= mac_bc_hit;
              if (!mac_loc_hit && !mac_bc_hit) state <= S_DROP;
            end else if (byte_cnt == 5'd12) begin
              if (e_rxd != 8'h08) state <= S_DROP;
            end else if (byte_cnt == 5'd13) begin
              if (e_rxd != 8'h00) begin
                state <= S_DROP;
              end else begin
                state    <= S_IP_HDR;
                byte_cnt <= 5'd0;
              end
            end
          end
        end
        S_IP_HDR: begin
          if (!e_rxdv) begin
            state <= S_IDLE;
          end else begin
            byte_cnt <= byte_cnt + 5'd1;
            case (byte_cnt)
              5'd0:  if (e_rxd != 8'h45) state <= S_DROP;
              5'd2:  total_len_sh[15:8] <= e_rxd;
              5'd3:  total_len_sh[7:0]  <= e_rxd;
              5'd9:  if (e_rxd != 8'h11) state <= S_DROP;
              5'd16, 5'd17, 5'd18: if (e_rxd != ip_byte) state <= S_DROP;
              5'd19: begin
                if (e_rxd != ip_byte) begin
                  state <= S_DROP;
                end else begin
                  state    <= S_UDP_HDR;
                  byte_cnt <= 5'd0;
                end
              end
              default: ;
            endcase
          end
        end
        S_UDP_HDR: begin
          if (!e_rxdv) begin
            state <= S_IDLE;
          end else begin
            byte_cnt <= byte_cnt + 5'd1;
            case (byte_cnt)
              5'd2: if (e_rxd != LOCAL_PORT[15:8]) state <= S_DROP;
              5'd3: if (e_rxd != LOCAL_PORT[7:0])  state <= S_DROP;
              5'd4: udp_len_sh[15:8] <= e_rxd;
              5'd5: begin
                udp_len_sh[7:0] <= e_rxd;
                if ({udp_len_sh[15:8], e_rxd} < 16'd8) state <= S_DROP;
              end
              5'd7: begin
                if (udp_len_sh == 16'd8) begin
                  state <= S_WAIT_END;
                end else begin
                  state     <= S_DATA;
                  data_left <= udp_len_sh - 16'd8;
                  pack      <= 64'd0;
                  lane      <= 3'd0;
                end
              end
              default: ;
            endcase
          end
        end
        S_DATA: begin
          if (!e_rxdv) begin
            state <= S_IDLE;
          end else begin
            data_left <= data_left - 16'd1;
            if ((lane == 3'd7) || (data_left == 16'd1)) begin
              if (fifo_full) begin
                rx_overflow <= 1'b1;
                ovf_err     <= 1'b1;
              end else begin
                wr_en <= 1'b1;
                dout  <= next_pack;
              end
              pack <= 64'd0;
              lane <= 3'd0;
            end else begin
              pack <= next_pack;
              lane <= lane + 3'd1;
            end
            if (data_left == 16'd1) state <= S_WAIT_END;
          end
        end
        S_WAIT_END: begin
          if (!e_rxdv) begin
            state <= S_IDLE;
            if (!ovf_err) begin
              rx_total_length <= total_len_sh;
              rx_data_length  <= udp_len_sh;
              data_receive    <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (!e_rxdv) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_unpack.sv
module tb_udp_rx_unpack;

  localparam logic [47:0] LOCAL_MAC  = 48'h000A_3501_FEC0;
  localparam logic [31:0] LOCAL_IP   = 32'hC0A8_0002;
  localparam logic [15:0] LOCAL_PORT = 16'd8080;

  typedef logic [7:0]  bq_t[$];
  typedef logic [63:0] wq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        e_rxdv = 1'b0;
  logic [7:0]  e_rxd = 8'h00;
  logic        fifo_full = 1'b0;
  logic        wr_en;
  logic [63:0] dout;
  logic [15:0] rx_total_length;
  logic [15:0] rx_data_length;
  logic        data_receive;
  logic        rx_overflow;
  logic [3:0]  rx_state;

  int n_pass = 0;
  int n_total = 0;

  logic [63:0] got_words[$];
  int          rcv_cnt = 0;
  int          ovf_cnt = 0;
  bit          saw_drop = 0;
  logic [15:0] m_tot = 16'd0;
  logic [15:0] m_dlen = 16'd0;

  udp_rx_unpack dut (
    .clk             (clk),
    .reset           (reset),
    .e_rxdv          (e_rxdv),
    .e_rxd           (e_rxd),
    .fifo_full       (fifo_full),
    .wr_en           (wr_en),
    .dout            (dout),
    .rx_total_length (rx_total_length),
    .rx_data_length  (rx_data_length),
    .data_receive    (data_receive),
    .rx_overflow     (rx_overflow),
    .rx_state        (rx_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en) got_words.push_back(dout);
    if (data_receive) rcv_cnt++;
    if (rx_overflow) ovf_cnt++;
    if (rx_state == 4'd7) saw_drop = 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bq_t build_frame(input bq_t pl, input logic [47:0] dmac,
                                      input logic [15:0] etype, input logic [7:0] verihl,
                                      input logic [7:0] proto, input logic [31:0] dip,
                                      input logic [15:0] dport, input logic [15:0] ulen);
    bq_t q;
    logic [15:0] tl;
    logic [47:0] smac;
    tl = ulen + 16'd20;
    smac = 48'h000A_3501_0203;
    q = {};
    repeat (7) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) q.push_back(dmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(smac[8*i +: 8]);
    q.push_back(etype[15:8]); q.push_back(etype[7:0]);
    q.push_back(verihl); q.push_back(8'h00);
    q.push_back(tl[15:8]); q.push_back(tl[7:0]);
    q.push_back(8'h00); q.push_back(8'h01); q.push_back(8'h40); q.push_back(8'h00);
    q.push_back(8'h40); q.push_back(proto); q.push_back(8'h00); q.push_back(8'h00);
    q.push_back(8'hC0); q.push_back(8'hA8); q.push_back(8'h00); q.push_back(8'h01);
    for (int i = 3; i >= 0; i--) q.push_back(dip[8*i +: 8]);
    q.push_back(8'h1F); q.push_back(8'h90);
    q.push_back(dport[15:8]); q.push_back(dport[7:0]);
    q.push_back(ulen[15:8]); q.push_back(ulen[7:0]);
    q.push_back(8'h00); q.push_back(8'h00);
    foreach (pl[i]) q.push_back(pl[i]);
    while (q.size() < 68) q.push_back(8'h00);
    q.push_back(8'hDE); q.push_back(8'hAD); q.push_back(8'hBE); q.push_back(8'hEF);
    return q;
  endfunction

  // Reference model: locates the SFD, reads header fields at their byte
  // offsets, and slices the payload into 8-byte groups. n is the number of
  // bytes actually sent before rxdv drops.
  task automatic model(input bq_t q, input int n, input bit ff,
                       output wq_t ew, output int er, output int eo);
    int p, b, L, last;
    bit ok;
    logic [47:0] dmac;
    logic [15:0] ulen;
    logic [63:0] w;
    ew = {}; er = 0; eo = 0;
    p = 0;
    while (p < q.size() && q[p] == 8'h55) p++;
    ok = (p >= 6) && (p < q.size()) && (q.size() >= p + 43);
    if (!ok) return;
    if (q[p] != 8'hD5) return;
    b = p + 1;
    dmac = {q[b], q[b+1], q[b+2], q[b+3], q[b+4], q[b+5]};
    ulen = {q[b+38], q[b+39]};
    ok = ((dmac == LOCAL_MAC) || (dmac == 48'hFFFF_FFFF_FFFF)) &&
         ({q[b+12], q[b+13]} == 16'h0800) && (q[b+14] == 8'h45) && (q[b+23] == 8'h11) &&
         ({q[b+30], q[b+31], q[b+32], q[b+33]} == LOCAL_IP) &&
         ({q[b+36], q[b+37]} == LOCAL_PORT) && (ulen >= 16'd8);
    if (!ok) return;
    L = int'(ulen) - 8;
    for (int w0 = 0; w0 < L; w0 += 8) begin
      last = ((w0 + 8 < L) ? w0 + 8 : L) - 1;
      if (b + 42 + last < n) begin
        w = '0;
        for (int k = 0; k < 8; k++)
          w = {w[55:0], ((w0 + k < L) ? q[b+42+w0+k] : 8'h00)};
        if (ff) eo++;
        else ew.push_back(w);
      end
    end
    if (n >= b + 42 + L && !ff) begin
      er = 1;
      m_tot = {q[b+16], q[b+17]};
      m_dlen = ulen;
    end
  endtask

  task automatic clear_mon();
    got_words.delete();
    rcv_cnt = 0;
    ovf_cnt = 0;
    saw_drop = 0;
  endtask

  task automatic send(input bq_t q, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e_rxdv = 1'b1;
      e_rxd = q[i];
    end
    @(negedge clk);
    e_rxdv = 1'b0;
    e_rxd = 8'h00;
    repeat (gap) @(posedge clk);
    #2;
  endtask

  function automatic bq_t good_frame(input int len);
    bq_t pl;
    pl = {};
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    return build_frame(pl, LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 16'(len + 8));
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({wr_en, dout, data_receive, rx_overflow} !== 67'd0) $display("FAIL reset_out: got wr=%b dout=%h rcv=%b ovf=%b want 0", wr_en, dout, data_receive, rx_overflow);
    else n_pass++;
    n_total++;
    if ({rx_total_length, rx_data_length} !== 32'd0) $display("FAIL reset_len: got %0d/%0d want 0/0", rx_total_length, rx_data_length);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (rx_state !== 4'd0) $display("FAIL reset_state: got %0d want 0", rx_state);
    else n_pass++;
  endtask

  task automatic test_hello();
    bq_t pl, q;
    wq_t ew;
    int er, eo;
    string s;
    logic [63:0] exp_w[3];
    exp_w[0] = 64'h48454C4C4F20414C;
    exp_w[1] = 64'h494E582041583531;
    exp_w[2] = 64'h494E582036200A0D;
    s = "HELLO ALINX AX51INX 6 \n\r";
    pl = {};
    for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
    q = build_frame(pl, LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 16'd32);
    clear_mon();
    model(q, q.size(), 1'b0, ew, er, eo);
    send(q, q.size(), 12);
    n_total++;
    if (got_words.size() !== 3) $display("FAIL hello_nwords: got %0d want 3", got_words.size());
    else n_pass++;
    for (int k = 0; k < 3 && k < got_words.size(); k++) begin
      n_total++;
      if (got_words[k] !== exp_w[k]) $display("FAIL hello_word%0d: got %h want %h", k, got_words[k], exp_w[k]);
      else n_pass++;
    end
    n_total++;
    if (rcv_cnt !== 1) $display("FAIL hello_rcv: got %0d pulses want 1", rcv_cnt);
    else n_pass++;
    n_total++;
    if (rx_total_length !== 16'd52 || rx_data_length !== 16'd32) $display("FAIL hello_len: got %0d/%0d want 52/32", rx_total_length, rx_data_length);
    else n_pass++;
  endtask

  task automatic test_short_payload();
    bq_t q;
    wq_t ew;
    int er, eo;
    q = good_frame(11);
    clear_mon();
    model(q, q.size(), 1'b0, ew, er, eo);
    send(q, q.size(), 12);
    n_total++;
    if (got_words.size() !== 2) $display("FAIL short_nwords: got %0d want 2", got_words.size());
    else n_pass++;
    if (got_words.size() == 2) begin
      n_total++;
      if (got_words[1][39:0] !== 40'd0) $display("FAIL short_pad: got %h want low 40 bits zero", got_words[1]);
      else n_pass++;
      n_total++;
      if (got_words[1] !== {q[58], q[59], q[60], 40'd0}) $display("FAIL short_word1: got %h want %h", got_words[1], {q[58], q[59], q[60], 40'd0});
      else n_pass++;
    end
    n_total++;
    if (rcv_cnt !== 1 || rx_data_length !== 16'd19 || rx_total_length !== 16'd39) $display("FAIL short_end: got rcv=%0d len=%0d/%0d want 1 39/19", rcv_cnt, rx_total_length, rx_data_length);
    else n_pass++;
  endtask

  task automatic test_bad_ip();
    bq_t pl, q;
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
    q = build_frame(pl, LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 32'hC0A8_0009, LOCAL_PORT, 16'd24);
    clear_mon();
    send(q, q.size(), 12);
    n_total++;
    if (got_words.size() !== 0 || rcv_cnt !== 0) $display("FAIL badip_out: got words=%0d rcv=%0d want 0/0", got_words.size(), rcv_cnt);
    else n_pass++;
    n_total++;
    if (saw_drop !== 1'b1 || rx_state !== 4'd0) $display("FAIL badip_state: got saw_drop=%b state=%0d want 1/0", saw_drop, rx_state);
    else n_pass++;
    n_total++;
    if (rx_total_length !== m_tot || rx_data_length !== m_dlen) $display("FAIL badip_len: got %0d/%0d want %0d/%0d", rx_total_length, rx_data_length, m_tot, m_dlen);
    else n_pass++;
  endtask

  task automatic test_abort();
    bq_t q;
    wq_t ew;
    int er, eo;
    q = good_frame(16);
    clear_mon();
    send(q, 54, 12);
    n_total++;
    if (got_words.size() !== 0 || rcv_cnt !== 0) $display("FAIL abort_out: got words=%0d rcv=%0d want 0/0", got_words.size(), rcv_cnt);
    else n_pass++;
    q = good_frame(20);
    clear_mon();
    model(q, q.size(), 1'b0, ew, er, eo);
    send(q, q.size(), 12);
    n_total++;
    if (got_words !== ew || rcv_cnt !== 1) $display("FAIL abort_next: got words=%0d rcv=%0d want words=%0d rcv=1", got_words.size(), rcv_cnt, ew.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    bq_t q;
    q = good_frame(24);
    clear_mon();
    fifo_full = 1'b1;
    send(q, q.size(), 12);
    fifo_full = 1'b0;
    n_total++;
    if (ovf_cnt !== 3) $display("FAIL ovf_count: got %0d want 3", ovf_cnt);
    else n_pass++;
    n_total++;
    if (got_words.size() !== 0 || rcv_cnt !== 0) $display("FAIL ovf_out: got words=%0d rcv=%0d want 0/0", got_words.size(), rcv_cnt);
    else n_pass++;
  endtask

  task automatic test_preamble();
    bq_t q;
    wq_t ew;
    int er, eo;
    q = good_frame(8);
    q.delete(0);
    clear_mon();
    model(q, q.size(), 1'b0, ew, er, eo);
    send(q, q.size(), 12);
    n_total++;
    if (rcv_cnt !== 1 || got_words !== ew) $display("FAIL pre6: got rcv=%0d words=%0d want 1/%0d", rcv_cnt, got_words.size(), ew.size());
    else n_pass++;
    q.delete(0);
    clear_mon();
    send(q, q.size(), 12);
    n_total++;
    if (rcv_cnt !== 0 || got_words.size() !== 0 || saw_drop !== 1'b1) $display("FAIL pre5: got rcv=%0d words=%0d drop=%b want 0/0/1", rcv_cnt, got_words.size(), saw_drop);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bq_t pl, q;
    wq_t ew;
    int er, eo;
    bit state_bad;
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'hA0 + 8'(i));
    q = build_frame(pl, LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 16'd24);
    clear_mon();
    state_bad = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      e_rxdv = 1'b1;
      e_rxd = q[i];
      if (i == 30) reset = 1'b1;
      if (i == 32) reset = 1'b0;
      if (i == 31) begin
        @(posedge clk);
        #1;
        n_total++;
        if ({wr_en, dout, data_receive, rx_overflow, rx_total_length, rx_data_length, rx_state} !== 103'd0)
          $display("FAIL midreset_out: got wr=%b rcv=%b len=%0d/%0d state=%0d want all 0", wr_en, data_receive, rx_total_length, rx_data_length, rx_state);
        else n_pass++;
      end
      if (i > 32) begin
        @(posedge clk);
        #1;
        if (rx_state != 4'd0 && rx_state != 4'd7) state_bad = 1;
      end
    end
    @(negedge clk);
    e_rxdv = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    m_tot = 16'd0;
    m_dlen = 16'd0;
    n_total++;
    if (state_bad || got_words.size() !== 0 || rcv_cnt !== 0) $display("FAIL midreset_rest: got state_bad=%b words=%0d rcv=%0d want 0/0/0", state_bad, got_words.size(), rcv_cnt);
    else n_pass++;
    q = good_frame(13);
    clear_mon();
    model(q, q.size(), 1'b0, ew, er, eo);
    send(q, q.size(), 12);
    n_total++;
    if (got_words !== ew || rcv_cnt !== 1 || rx_data_length !== 16'd21) $display("FAIL midreset_next: got words=%0d rcv=%0d dlen=%0d want %0d/1/21", got_words.size(), rcv_cnt, rx_data_length, ew.size());
    else n_pass++;
  endtask

  task automatic test_random_frames(input int count, input int gap);
    bq_t pl, q;
    wq_t ew;
    int er, eo, n, mode, len;
    logic [47:0] dmac;
    logic [15:0] et, ulen, dport;
    logic [7:0] vi, pr;
    logic [31:0] dip;
    bit ff;
    for (int f = 0; f < count; f++) begin
      mode = $urandom_range(0, 11);
      len = $urandom_range(0, 40);
      pl = {};
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      dmac = LOCAL_MAC; et = 16'h0800; vi = 8'h45; pr = 8'h11;
      dip = LOCAL_IP; dport = LOCAL_PORT; ulen = 16'(len + 8); ff = 0;
      case (mode)
        0: dmac = LOCAL_MAC ^ (48'h1 << (8 * $urandom_range(0, 5)));
        1: et = 16'h86DD;
        2: vi = 8'h46;
        3: pr = 8'h06;
        4: dip = LOCAL_IP ^ 32'h0000_0F00;
        5: dport = 16'd8081;
        6: begin ulen = 16'($urandom_range(0, 7)); pl = {}; end
        7: dmac = 48'hFFFF_FFFF_FFFF;
        8: ff = 1;
        default: ;
      endcase
      q = build_frame(pl, dmac, et, vi, pr, dip, dport, ulen);
      n = (mode == 9) ? $urandom_range(1, q.size() - 1) : q.size();
      clear_mon();
      model(q, n, ff, ew, er, eo);
      fifo_full = ff;
      send(q, n, gap);
      fifo_full = 1'b0;
      n_total++;
      if (got_words.size() !== ew.size()) $display("FAIL rand%0d_nwords: mode %0d got %0d want %0d", f, mode, got_words.size(), ew.size());
      else n_pass++;
      for (int k = 0; k < ew.size() && k < got_words.size(); k++) begin
        n_total++;
        if (got_words[k] !== ew[k]) $display("FAIL rand%0d_word%0d: got %h want %h", f, k, got_words[k], ew[k]);
        else n_pass++;
      end
      n_total++;
      if (rcv_cnt !== er || ovf_cnt !== eo) $display("FAIL rand%0d_flags: mode %0d got rcv=%0d ovf=%0d want %0d/%0d", f, mode, rcv_cnt, ovf_cnt, er, eo);
      else n_pass++;
      n_total++;
      if (rx_total_length !== m_tot || rx_data_length !== m_dlen) $display("FAIL rand%0d_len: got %0d/%0d want %0d/%0d", f, rx_total_length, rx_data_length, m_tot, m_dlen);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_short_payload();
    test_bad_ip();
    test_abort();
    test_overflow();
    test_preamble();
    test_reset_mid();
    test_random_frames(30, 12);
    test_random_frames(20, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
